ula_serial_seq: RTL and testbench
=================================

# ula_serial_seq

Bit-serial sequencer that drives the existing 1-bit `ula` slice to execute full-width MIPS ALU operations, one bit per clock, LSB first. It sits directly upstream of the slice: it accepts a word-level request, feeds the slice's `a`, `b`, `cin`, `addsub` and `ULAcontrole` inputs each cycle, and collects `ULAsaida` into a result register. It also generates the carry chain, overflow, zero and set-less-than that the slice cannot produce on its own.

## Interface
- `WIDTH`, default 32: operand and result width; minimum 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE or DONE.
- `op`  in  3  operation code (codes in `ula_pkg`).
- `op_a`  in  WIDTH  operand A; captured on an accepted `start`.
- `op_b`  in  WIDTH  operand B; captured on an accepted `start`.
- `busy`  out  1  high while a request is in progress.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  WIDTH  final result; held until the next accepted `start` or `rst`.
- `zero`  out  1  `result == 0`; valid when `done` is high and held afterwards.
- `overflow`  out  1  signed overflow for ADD/SUB; 0 for all other ops.

## Operation
- Op codes:
  - AND=000, OR=001, ADD=010, SUB=110, SLT=111.
  - Any other code is unsupported: the request runs the full length, then `result`=0, `zero`=1, `overflow`=0.
- The slice's `addsub` input is driven with `op[2]`.
- For SLT, the slice's `ULAcontrole` is driven with SUB. For all other ops it is driven with `op`.
- FSM states:
  - IDLE: `start` → RUN. On this edge the block latches `op`, `op_a` and `op_b` into shift registers and sets `cnt`=0 and `carry`=`op[2]`.
  - RUN: every cycle, bit `cnt` of A and B and `carry` are presented to the slice.
    - `ULAsaida` is shifted into the result register from the MSB side.
    - `carry` is updated to maj(a, b^addsub, carry).
    - `cnt` increments.
    - When `cnt`==WIDTH-1 the state moves to DONE.
  - DONE: `done`=1 for exactly one cycle.
    - `start` → RUN (back-to-back request, same latching as from IDLE).
    - Otherwise → IDLE.
- MSB handling:
  - `c_in31` is the carry into the MSB; `c_out31` is the carry out of the MSB.
  - `overflow` = `c_in31 ^ c_out31` for ADD and SUB.
  - SLT: `result` = {0…0, `sum[MSB] ^ ovf`}.
- `start` in RUN is ignored. Operands, op and count are not disturbed.
- `rst` takes effect in any state, including mid-RUN. The partial result is discarded.
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, `zero`=0, `overflow`=0, `cnt`=0.

## Timing
- The accepting edge is T.
- `busy` is high from after edge T to edge T+WIDTH. `busy` is low in DONE.
- `done`, `result`, `zero` and `overflow` are registered and visible in the cycle after edge T+WIDTH.
- Latency is WIDTH clocks from acceptance to `done`.
- Throughput is one operation per WIDTH+1 clocks. This includes back-to-back acceptance in the DONE cycle.
- `result` changes only on the DONE-entry edge or on `rst`. Intermediate shift contents are never visible.

## Configuration
- `ULA_SERIAL_SLT_EN` defined: SLT (111) is supported as described above.
- Macro absent:
  - 111 is treated as an unsupported code, giving `result`=0 and `zero`=1.
  - The less-than logic is not compiled in.
  - ADD and SUB overflow logic remains.

## Structure
- `ula_pkg` holds:
  - op-code localparams `ULA_AND`, `ULA_OR`, `ULA_ADD`, `ULA_SUB`, `ULA_SLT`;
  - the state enum `ula_seq_state_t` (IDLE, RUN, DONE).
- One sub-module: the existing `ula` 1-bit slice, instantiated once. Everything else is inline in `ula_serial_seq`.

## Test plan
All scenarios use WIDTH=32.
- ADD, 0x0000_0005 + 0x0000_0003 → `result`=0x0000_0008, `overflow`=0, `zero`=0. `done` rises exactly 32 clocks after the accepting edge.
- SUB, 0x7FFF_FFFF − 0xFFFF_FFFF → `result`=0x8000_0000, `overflow`=1.
- SLT comparisons:
  - 0xFFFF_FFFE vs 0x0000_0001 → `result`=1.
  - 0x8000_0000 vs 0x7FFF_FFFF → `result`=1 (overflow-corrected).
  - 0x0000_0005 vs 0x0000_0005 → `result`=0, `zero`=1.
- Logic ops:
  - AND, 0xF0F0_F0F0 & 0x0FF0_0FF0 → `result`=0x00F0_00F0.
  - OR on the same operands → `result`=0xFFF0_FFF0.
  - AND, 0xAAAA_AAAA & 0x5555_5555 → `result`=0, `zero`=1.
- Control behaviour during a request:
  - A second `start` 5 cycles into an ADD, with different operands, is ignored and the first result is unchanged.
  - `rst` 10 cycles into an ADD → the next cycle shows `busy`=0, `done`=0, `result`=0.
- Back-to-back request:
  - `start` held high in the DONE cycle (OR, then ADD 1+1) → the second request is accepted with no IDLE cycle.
  - The second `done` arrives 33 clocks after the first, with `result`=0x0000_0002.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg
// Shared definitions for the bit-serial ALU sequencer and its 1-bit slice.
//   - Op-code localparams (MIPS-style ALU control codes).
//   - Sequencer state enum ula_seq_state_t (IDLE, RUN, DONE).
package ula_pkg;

  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } ula_seq_state_t;

endpackage

// File: rtl/ula_serial_seq_ula.sv
// ula
// Existing 1-bit ALU slice. Purely combinational.
// Ports:
//   a, b         operand bits
//   cin          carry into this bit
//   addsub       1 inverts b for subtraction (used with cin=1 on bit 0)
//   ULAcontrole  3-bit operation code (see ula_pkg)
//   ULAsaida     result bit (AND, OR, or sum bit); 0 for codes it does not handle
module ula
  import ula_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       addsub,
  input  logic [2:0] ULAcontrole,
  output logic       ULAsaida
);

  logic b_eff;

  assign b_eff = b ^ addsub;

  always_comb begin
    ULAsaida = 1'b0;
    case (ULAcontrole)
      ULA_AND:          ULAsaida = a & b;
      ULA_OR:           ULAsaida = a | b;
      ULA_ADD, ULA_SUB: ULAsaida = a ^ b_eff ^ cin;
      default:          ULAsaida = 1'b0;
    endcase
  end

endmodule

// File: rtl/ula_serial_seq.sv
// ula_serial_seq
// Bit-serial sequencer: executes a full-width ALU operation on the 1-bit
// `ula` slice, one bit per clock, LSB first, and produces carry chain,
// signed overflow, zero flag and (optionally) set-less-than.
// Configuration macro: ULA_SERIAL_SLT_EN -- when defined, op 111 (SLT) is
// supported; otherwise 111 behaves like any unsupported code.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         request strobe, accepted in IDLE or DONE only
//   op            3-bit operation code
//   op_a, op_b    WIDTH-bit operands, captured on an accepted start
//   busy          high while the bits are being processed
//   done          one-cycle completion pulse
//   result        final result, held until the next accepted start or reset
//   zero          result == 0
//   overflow      signed overflow for ADD/SUB, 0 otherwise
module ula_serial_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  ula_seq_state_t   state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] acc;
  logic [2:0]       op_r;
  logic             carry;

  logic             addsub;
  logic [2:0]       slice_ctl;
  logic             slice_out;
  logic             b_eff;
  logic             carry_nxt;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] final_sum;
  logic [WIDTH-1:0] final_res;
  logic             final_ovf;

  assign addsub = op_r[2];
  assign b_eff  = b_sh[0] ^ addsub;
  // Carry out of the bit currently in the slice; on the last bit, carry is
  // c_in31 and carry_nxt is c_out31.
  assign carry_nxt = (a_sh[0] & b_eff) | (a_sh[0] & carry) | (b_eff & carry);

`ifdef ULA_SERIAL_SLT_EN
  assign slice_ctl = (op_r == ULA_SLT) ? ULA_SUB : op_r;
`else
  assign slice_ctl = op_r;
`endif

  ula u_ula (
    .a           (a_sh[0]),
    .b           (b_sh[0]),
    .cin         (carry),
    .addsub      (addsub),
    .ULAcontrole (slice_ctl),
    .ULAsaida    (slice_out)
  );

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // The accumulator holds the WIDTH-1 bits already produced; joining it with
  // the current slice output gives the complete word on the last bit.
  assign final_sum = {slice_out, acc};

  always_comb begin
    final_res = '0;
    final_ovf = 1'b0;
    case (op_r)
      ULA_AND, ULA_OR: final_res = final_sum;
      ULA_ADD, ULA_SUB: begin
        final_res = final_sum;
        final_ovf = carry ^ carry_nxt;
      end
`ifdef ULA_SERIAL_SLT_EN
      // Sign of the difference, corrected when the subtraction overflowed.
      ULA_SLT: final_res = {{(WIDTH-1){1'b0}}, slice_out ^ (carry ^ carry_nxt)};
`endif
      default: final_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand shifters, carry, bit counter and result registers.
  // Visible outputs are only written on the DONE-entry edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      op_r     <= ULA_AND;
      carry    <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh  <= op_a;
      b_sh  <= op_b;
      op_r  <= op;
      cnt   <= '0;
      carry <= op[2];
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      acc   <= final_sum[WIDTH-1:1];
      carry <= carry_nxt;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        result   <= final_res;
        zero     <= (final_res == '0);
        overflow <= final_ovf;
      end
    end
  end

endmodule

// File: tb/tb_ula_serial_seq.sv
// tb_ula_serial_seq
// Self-checking bench for ula_serial_seq (WIDTH=32). A word-level reference
// model tracks the expected visible outputs every cycle; directed scenarios
// add literal expectations. Honours ULA_SERIAL_SLT_EN the same way as the RTL.
module tb_ula_serial_seq;

  localparam int W = 32;
`ifdef ULA_SERIAL_SLT_EN
  localparam bit SLT_ON = 1'b1;
`else
  localparam bit SLT_ON = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, zero, overflow;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int accept_cyc = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic         m_busy, m_done, m_zero, m_ovf;
  logic [W-1:0] m_res;
  int           m_left;
  exp_t         m_pend;

  ula_serial_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word-level meaning of each op code
  function automatic exp_t ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.res = '0;
    e.v   = 1'b0;
    case (o)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b010: begin
        e.res = a + b;
        e.v   = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      3'b110: begin
        e.res = a - b;
        e.v   = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      3'b111: e.res = (SLT_ON && ($signed(a) < $signed(b))) ? 1 : 0;
      default: e.res = '0;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Request timing model: accepted when not busy, completes WIDTH edges later
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_zero <= 1'b0;
      m_ovf  <= 1'b0;
      m_left <= 0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= m_pend.res;
        m_zero <= m_pend.z;
        m_ovf  <= m_pend.v;
      end
      m_left <= m_left - 1;
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_busy <= 1'b1;
        m_left <= W;
        m_pend <= ref_op(op, op_a, op_b);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("busy",     W'(busy),     W'(m_busy));
      checkOutput("done",     W'(done),     W'(m_done));
      checkOutput("result",   result,       m_res);
      checkOutput("zero",     W'(zero),     W'(m_zero));
      checkOutput("overflow", W'(overflow), W'(m_ovf));
    end
  end

  // Present a request; with now=1 the caller is already at a negedge
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit now);
    if (!now) @(negedge clk);
    start = 1'b1;
    op    = o;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - accept_cyc;
        break;
      end
    end
    if (lat < 0) checkOutput("done_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int d1, d2;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = 3'b000; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    checkOutput("rst_busy",   W'(busy),     0);
    checkOutput("rst_done",   W'(done),     0);
    checkOutput("rst_result", result,       0);
    checkOutput("rst_zero",   W'(zero),     0);
    checkOutput("rst_ovf",    W'(overflow), 0);
    rst = 1'b0;

    $display("[TB] ADD 5+3");
    applyStimulus(3'b010, 32'h0000_0005, 32'h0000_0003, 0);
    waitDone(lat);
    checkOutput("add_latency", lat,            32);
    checkOutput("add_result",  result,         32'h0000_0008);
    checkOutput("add_model",   m_res,          32'h0000_0008);
    checkOutput("add_ovf",     W'(overflow),   0);
    checkOutput("add_zero",    W'(zero),       0);

    $display("[TB] SUB 7FFFFFFF-FFFFFFFF");
    applyStimulus(3'b110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
    waitDone(lat);
    checkOutput("sub_result", result,       32'h8000_0000);
    checkOutput("sub_ovf",    W'(overflow), 1);
    checkOutput("sub_model",  W'(m_ovf),    1);

    $display("[TB] SLT cases");
    applyStimulus(3'b111, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    waitDone(lat);
    checkOutput("slt_neg", result, W'(SLT_ON));
    applyStimulus(3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 0);
    waitDone(lat);
    checkOutput("slt_ovfcorr", result, W'(SLT_ON));
    checkOutput("slt_ovfcorr_ovf", W'(overflow), 0);
    applyStimulus(3'b111, 32'h0000_0005, 32'h0000_0005, 0);
    waitDone(lat);
    checkOutput("slt_eq",      result,   0);
    checkOutput("slt_eq_zero", W'(zero), 1);

    $display("[TB] logic ops");
    applyStimulus(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
    waitDone(lat);
    checkOutput("and_result", result, 32'h00F0_00F0);
    applyStimulus(3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
    waitDone(lat);
    checkOutput("or_result", result, 32'hFFF0_FFF0);
    applyStimulus(3'b000, 32'hAAAA_AAAA, 32'h5555_5555, 0);
    waitDone(lat);
    checkOutput("and_zero_result", result,   0);
    checkOutput("and_zero_flag",   W'(zero), 1);

    $display("[TB] unsupported op");
    applyStimulus(3'b011, 32'h1234_5678, 32'h0000_0001, 0);
    waitDone(lat);
    checkOutput("unsup_result", result,   0);
    checkOutput("unsup_zero",   W'(zero), 1);

    $display("[TB] start ignored while running");
    applyStimulus(3'b010, 32'h0000_0005, 32'h0000_0003, 0);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'b001; op_a = 32'hDEAD_BEEF; op_b = 32'h0101_0101;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(lat);
    checkOutput("ignored_latency", lat,    32);
    checkOutput("ignored_result",  result, 32'h0000_0008);

    $display("[TB] reset mid-run");
    applyStimulus(3'b010, 32'h0000_1234, 32'h0000_0001, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy",   W'(busy), 0);
    checkOutput("midrst_done",   W'(done), 0);
    checkOutput("midrst_result", result,   0);

    $display("[TB] back-to-back");
    applyStimulus(3'b001, 32'h0000_00F0, 32'h0000_000F, 0);
    waitDone(lat);
    d1 = cyc;
    checkOutput("b2b_first", result, 32'h0000_00FF);
    applyStimulus(3'b010, 32'h0000_0001, 32'h0000_0001, 1);
    checkOutput("b2b_busy", W'(busy), 1);
    waitDone(lat);
    d2 = cyc;
    checkOutput("b2b_spacing", d2 - d1, 33);
    checkOutput("b2b_result",  result,  32'h0000_0002);

    $display("[TB] randomized requests");
    for (int k = 0; k < 40; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h7FFF_FFFF;
        1: rb = 32'h8000_0000;
        2: rb = ra;
        default: ;
      endcase
      applyStimulus(ro, ra, rb, ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
        start = 1'b1; op = 3'($urandom_range(0, 7)); op_a = $urandom; op_b = $urandom;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      waitDone(lat);
      checkOutput("rand_latency", lat, 32);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
